// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate over a length-prefixed dot product.
// A start in IDLE latches the length. Each operand handshake adds a*b to the
// accumulator. The shifted, saturated result is held in DONE until the
// consumer takes it.
module mac_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 0,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out,
  output logic                         sat,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Clip bounds expressed at accumulator width so the compare is a plain signed compare.
  localparam logic signed [ACC_WIDTH-1:0] OMAX =
    ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OMIN = ~OMAX;

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [LEN_WIDTH-1:0]         count_q, count_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic                         sat_q, sat_d;
  logic                         enter_done;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    shifted;

  assign prod     = a * b;
  assign prod_ext = ACC_WIDTH'(prod);
  assign shifted  = acc_d >>> SHIFT;

  // Next-state and datapath: acc/count move only on a handshake in ACCUM.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    len_d      = len_q;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          len_d   = len;
          if (len == '0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = acc_q + prod_ext;
          count_d = count_q + LEN_WIDTH'(1);
          if (count_d == len_q) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is computed once from the final accumulator and then frozen.
  always_comb begin
    out_d = out_q;
    sat_d = sat_q;
    if (enter_done) begin
      if (shifted > OMAX) begin
        out_d = OMAX[OUT_WIDTH-1:0];
        sat_d = 1'b1;
      end else if (shifted < OMIN) begin
        out_d = OMIN[OUT_WIDTH-1:0];
        sat_d = 1'b1;
      end else begin
        out_d = shifted[OUT_WIDTH-1:0];
        sat_d = 1'b0;
      end
    end
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out       = out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a vector table plus hand-written corner sequences.
// A second instance with SHIFT=4 receives the same stimulus.
module tb_mac_accumulator;

  logic              clk, rst_n, start, in_valid, out_ready;
  logic [7:0]        len;
  logic signed [7:0] a, b;
  logic              in_ready, out_valid, sat, busy;
  logic signed [7:0] out;
  logic              in_ready_s, out_valid_s, sat_s, busy_s;
  logic signed [7:0] out_s;

  int errors = 0;
  int checks = 0;

  mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .sat(sat), .busy(busy)
  );

  mac_accumulator #(.SHIFT(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready_s), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .out(out_s), .sat(sat_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [7:0]       eo;
    logic             es;
    logic [7:0]       eos;
    logic             ess;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input int l, input int a0, input int b0, input int a1, input int b1,
                              input int a2, input int b2, input int a3, input int b3,
                              input int eo, input int es, input int eos, input int ess);
    vec_t v;
    v.len  = 8'(l);
    v.a[0] = 8'(a0); v.b[0] = 8'(b0);
    v.a[1] = 8'(a1); v.b[1] = 8'(b1);
    v.a[2] = 8'(a2); v.b[2] = 8'(b2);
    v.a[3] = 8'(a3); v.b[3] = 8'(b3);
    v.eo   = 8'(eo);  v.es  = es[0];
    v.eos  = 8'(eos); v.ess = ess[0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input int l);
    @(posedge clk); #1;
    start = 1'b1; len = 8'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    out_ready = 1'b1;
    do_start(int'(v.len));
    for (int i = 0; i < int'(v.len); i++) begin
      in_valid = 1'b1; a = v.a[i]; b = v.b[i];
      @(negedge clk);
      chk("in_ready", int'(in_ready), 1);
      if (i == int'(v.len) - 1) chk("valid_early", int'(out_valid), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("out_valid", int'(out_valid), 1);
    chk("out", int'(out), int'($signed(v.eo)));
    chk("sat", int'(sat), int'(v.es));
    chk("out_shift4", int'(out_s), int'($signed(v.eos)));
    chk("sat_shift4", int'(sat_s), int'(v.ess));
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_pulse", int'(out_valid), 0);
  endtask

  initial begin
    int iv[7];
    iv = '{1, 0, 0, 1, 1, 0, 1};
    //            len  a0   b0   a1  b1  a2  b2  a3  b3   out   sat  out>>4 sat
    vecs[0]  = mk(3,   2,   3,   4,  5, -1,  6,  0,  0,   20,  0,    1, 0);
    vecs[1]  = mk(4, 127, 127, 127,127,127,127,127,127,  127,  1,  127, 1);
    vecs[2]  = mk(2,-128, 127,-128,127,  0,  0,  0,  0, -128,  1, -128, 1);
    vecs[3]  = mk(1,   3,   3,   0,  0,  0,  0,  0,  0,    9,  0,    0, 0);
    vecs[4]  = mk(2,  10,  -5,   3,  4,  0,  0,  0,  0,  -38,  0,   -3, 0);
    vecs[5]  = mk(1,-128,-128,   0,  0,  0,  0,  0,  0,  127,  1,  127, 1);
    vecs[6]  = mk(2, 127,   1,   0,  0,  0,  0,  0,  0,  127,  0,    7, 0);
    vecs[7]  = mk(2,-128,   1,   0,  5,  0,  0,  0,  0, -128,  0,   -8, 0);
    vecs[8]  = mk(2,  64,   2,   0,  0,  0,  0,  0,  0,  127,  1,    8, 0);
    vecs[9]  = mk(1,  -1,   1,   0,  0,  0,  0,  0,  0,   -1,  0,   -1, 0);
    vecs[10] = mk(1,  50,  40,   0,  0,  0,  0,  0,  0,  127,  1,  125, 0);

    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_out", int'(out), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Input gaps: only cycles with in_valid=1 count; accepted a = 1,4,5,7 with b=2 -> 34.
    out_ready = 1'b1;
    do_start(4);
    for (int i = 0; i < 7; i++) begin
      in_valid = iv[i][0]; a = 8'(i + 1); b = 8'sd2;
      @(negedge clk);
      chk("gap_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("gap_valid", int'(out_valid), 1);
    chk("gap_out", int'(out), 34);
    chk("gap_out_shift4", int'(out_s), 2);
    @(posedge clk); #1;

    // Backpressure: result held, start ignored, no operand acceptance.
    out_ready = 1'b0;
    do_start(1);
    in_valid = 1'b1; a = 8'sd5; b = 8'sd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = 8'd3; in_valid = 1'b1; a = 8'sd9; b = 8'sd9;
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_out", int'(out), 25);
      chk("bp_sat", int'(sat), 0);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_busy", int'(busy), 1);
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_busy", int'(busy), 0);
    chk("idle_out_hold", int'(out), 25);
    chk("idle_out_hold_shift4", int'(out_s), 1);

    // len=0: result 0 on the cycle after start.
    do_start(0);
    @(negedge clk);
    chk("len0_valid", int'(out_valid), 1);
    chk("len0_out", int'(out), 0);
    chk("len0_sat", int'(sat), 0);
    @(posedge clk); #1;

    // Reset after 2 of 5 transfers abandons the operation.
    do_start(5);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 8'sd7; b = 8'sd7;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_out", int'(out), 0);
    chk("mid_rst_sat", int'(sat), 0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", int'(out_valid), 0);
      chk("post_rst_busy", int'(busy), 0);
    end
    run_vec(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
